// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between the command logic (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_ok, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_ok, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// byte out LSB first on device clock falls and reports ACK, completion or timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned SETUP_CYCLES   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic         CLK,
  input  logic         RST,
  ps2_host_tx_if.slave cmd,
  input  logic         PS2_CLK,
  input  logic         PS2_DAT,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > SETUP_CYCLES) ? MAX_A : SETUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_REL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             dat_bit_q, dat_bit_d;
  logic             ack_ok_q, ack_ok_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             clk_meta_q, clk_meta_d;
  logic             clk_sync_q, clk_sync_d;
  logic             clk_prev_q, clk_prev_d;
  logic             dat_meta_q, dat_meta_d;
  logic             dat_sync_q, dat_sync_d;

  logic       fall;
  logic [3:0] bit_next;
  logic       abort;

  assign fall     = clk_prev_q & ~clk_sync_q;
  assign bit_next = (bit_cnt_q == 4'd11) ? 4'd11 : bit_cnt_q + 4'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      dat_bit_q  <= 1'b0;
      ack_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      dat_bit_q  <= dat_bit_d;
      ack_ok_q   <= ack_ok_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    dat_bit_d  = dat_bit_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    abort      = 1'b0;
    clk_meta_d = PS2_CLK;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = PS2_DAT;
    dat_sync_d = dat_meta_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        dat_bit_d = 1'b0;
        if (cmd.tx_valid) begin
          shift_d   = cmd.tx_data;
          parity_d  = ~^cmd.tx_data;
          ack_ok_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        // Leaving REQ keeps data pulled low: that is the start bit the device clocks in first.
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          dat_bit_d = 1'b1;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = bit_next;
          if (bit_next <= 4'd8) begin
            dat_bit_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (bit_next == 4'd9) begin
            dat_bit_d = ~parity_q;
          end else if (bit_next == 4'd10) begin
            dat_bit_d = 1'b0;
          end else begin
            ack_ok_d  = ~dat_sync_q;
            dat_bit_d = 1'b0;
            state_d   = S_WAIT_REL;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      ack_ok_d  = 1'b0;
      dat_bit_d = 1'b0;
      cnt_d     = '0;
      state_d   = S_IDLE;
    end
  end

  assign ps2_clk_oe   = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_dat_oe   = (state_q == S_REQ) || ((state_q == S_SEND) && dat_bit_q);
  assign cmd.tx_ready = (state_q == S_IDLE);
  assign cmd.busy     = (state_q != S_IDLE);
  assign cmd.done     = done_q;
  assign cmd.ack_ok   = ack_ok_q;
  assign cmd.timeout  = timeout_q;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Shares the PS2_CLK/PS2_DAT lines with the existing keyboard receiver path in MAIN.
- Drives both lines open-drain through active-high pull-low enables.
- Reports completion, device ACK status and timeout to the command logic.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles the clock line is held low before the request (100 us at 50 MHz)
SETUP_CYCLES, 50, CLK cycles data and clock are both held low before the clock is released
TIMEOUT_CYCLES, 750000, max CLK cycles between device clock falling edges, and for the final line release, before abort (15 ms)

Ports:
CLK         in   1  system clock
RST         in   1  synchronous active-high reset
tx_data     in   8  command byte
tx_valid    in   1  request to send tx_data
tx_ready    out  1  block idle, accepts request
PS2_CLK     in   1  PS/2 clock pin (read back)
PS2_DAT     in   1  PS/2 data pin (read back)
ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release
busy        out  1  transfer in progress
done        out  1  one-cycle pulse, transfer finished
ack_ok      out  1  device ACK seen; valid with done, held until next accept
timeout     out  1  one-cycle pulse, transfer aborted

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RST).
- Reset values: tx_ready=1; ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, timeout all 0; state=IDLE; counters 0.
- RST mid-transfer releases both lines on the next edge; no done or timeout pulse.
- Inputs: PS2_CLK and PS2_DAT pass through a 2-FF synchronizer. fall = synced clock was 1 last cycle and is 0 now (3-cycle pin-to-fall latency).
- Accept: tx_valid && tx_ready on edge N:
  - latch tx_data;
  - parity = ~^tx_data (odd parity);
  - clear ack_ok and bit counter;
  - from N+1: tx_ready=0, busy=1, ps2_clk_oe=1.
- tx_valid while busy is ignored.
- States:
  - IDLE: clk_oe=0, dat_oe=0. Go to INHIBIT on accept.
  - INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit 0 on line) for exactly SETUP_CYCLES cycles, then SEND.
  - SEND: clk_oe=0. On each fall, bit counter k increments (1..11). The line value is updated in the cycle the fall is detected:
    - k=1..8: dat_oe = ~tx_data[k-1] (LSB first);
    - k=9: dat_oe = ~parity;
    - k=10: dat_oe = 0 (stop bit, line released);
    - k=11: sample synced PS2_DAT; ack_ok = (sample==0). Go to WAIT_REL.
  - WAIT_REL: both oe=0. When synced clock=1 and synced data=1 for one cycle: pulse done, go IDLE (busy=0, tx_ready=1 on the following cycle).
- Timeout:
  - In SEND and WAIT_REL, a counter resets on every fall and on entry, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: both oe=0 next cycle, timeout pulses once, ack_ok=0, return to IDLE. No done pulse.
  - INHIBIT and REQ are never subject to timeout.
- ACK sampled high (NACK): done still pulses, with ack_ok=0.
- done and timeout are never high in the same cycle.
- Counter widths: wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) with no wrap. Bit counter is 4 bits and saturates at 11.

Test Plan:
Bench parameters for all scenarios: INHIBIT_CYCLES=20, SETUP_CYCLES=4, TIMEOUT_CYCLES=200. The bench device model clocks at a 40-cycle period and samples on rising edges.
1. Reset then idle -> tx_ready=1, both oe=0, busy=0, done=0, timeout=0.
2. Send 0xED with ACK -> clk_oe high for exactly 20 cycles; then dat_oe=1 with clk_oe=1 for 4 cycles. Device captures data 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once with ack_ok=1; tx_ready returns 1.
3. Send 0x01, device omits ACK (data stays high at fall 11) -> parity bit 0 captured; done pulses with ack_ok=0.
4. Device never clocks after REQ -> 200 cycles after entering SEND: timeout pulses once, both oe=0, tx_ready=1, no done.
5. Assert RST during data bit 4 of 0xFF -> next cycle both oe=0, busy=0, no done/timeout. A following 0x00 send completes correctly with parity 1.
6. tx_valid held high across a 0xF4 transfer with tx_data changed mid-transfer -> device receives 0xF4 unchanged. A second transfer is accepted only on the cycle after tx_ready returns to 1.
